// File: rtl/tlul_xbar_mxn.sv
`default_nettype none
// ============================================================================
// Module   : tlul_xbar_mxn (plus package tlul_xbar_pkg)
// Purpose  : M-host by N-device TL-UL crossbar. Each host address is decoded
//            against a base/mask map (lowest device index wins on overlap).
//            Each device has its own arbiter, and each host allows one
//            outstanding request. Unmapped requests go to a per-host error
//            responder.
// Ports    : clk_i   - clock, rising edge
//            rst_ni  - synchronous active-low reset
//            tl_h_i  - host A channel + d_ready      [NumHosts]
//            tl_h_o  - host D channel + a_ready      [NumHosts]
//            tl_d_o  - device A channel + d_ready    [NumDevs]
//            tl_d_i  - device D channel + a_ready    [NumDevs]
// Config   : TLUL_XBAR_RR_ARB_EN - per-device round-robin arbitration
//            (default: fixed priority, lowest host index wins)
// Revision : 1.0 - initial release
// ============================================================================

package tlul_xbar_pkg;
    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    localparam logic [2:0] c_OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] c_OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] c_OP_GET         = 3'd4;
    localparam logic [2:0] c_OP_ACK         = 3'd0;
    localparam logic [2:0] c_OP_ACK_DATA    = 3'd1;
endpackage

module tlul_xbar_mxn
    import tlul_xbar_pkg::*;
#(
    parameter int unsigned NumHosts = 2,
    parameter int unsigned NumDevs  = 11,
    parameter logic [31:0] AddrBase [NumDevs] = '{default: '0},
    parameter logic [31:0] AddrMask [NumDevs] = '{default: '0}
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  tl_h2d_t tl_h_i [NumHosts],
    output tl_d2h_t tl_h_o [NumHosts],
    output tl_h2d_t tl_d_o [NumDevs],
    input  tl_d2h_t tl_d_i [NumDevs]
);

    localparam int unsigned HW = (NumHosts > 1) ? $clog2(NumHosts) : 1;
    localparam int unsigned DW = (NumDevs > 1) ? $clog2(NumDevs) : 1;

    localparam logic [0:0] c_H_IDLE = 1'b0;
    localparam logic [0:0] c_H_WAIT = 1'b1;
    localparam logic [0:0] c_D_IDLE = 1'b0;
    localparam logic [0:0] c_D_BUSY = 1'b1;

    logic [0:0]    host_state_q [NumHosts], host_state_d [NumHosts];
    logic          err_valid_q  [NumHosts], err_valid_d  [NumHosts];
    logic [2:0]    err_opcode_q [NumHosts], err_opcode_d [NumHosts];
    logic [1:0]    err_size_q   [NumHosts], err_size_d   [NumHosts];
    logic [7:0]    err_source_q [NumHosts], err_source_d [NumHosts];
    logic [0:0]    dev_state_q  [NumDevs],  dev_state_d  [NumDevs];
    logic [HW-1:0] dev_owner_q  [NumDevs],  dev_owner_d  [NumDevs];
`ifdef TLUL_XBAR_RR_ARB_EN
    logic [HW-1:0] rr_ptr_q     [NumDevs],  rr_ptr_d     [NumDevs];
`endif

    logic          host_hit  [NumHosts];
    logic [DW-1:0] host_dev  [NumHosts];
    logic          host_req  [NumHosts];
    logic          host_a_hs [NumHosts];
    logic          host_d_hs [NumHosts];
    logic          gnt_valid [NumDevs];
    logic [HW-1:0] gnt_idx   [NumDevs];

`ifdef TLUL_XBAR_RR_ARB_EN
    // Host index visited at step `off` of a search that starts at `ptr`.
    function automatic int unsigned rr_idx(input int unsigned ptr, input int unsigned off);
        return (ptr + off >= NumHosts) ? (ptr + off - NumHosts) : (ptr + off);
    endfunction
`endif

    // Decode loop runs downwards so the lowest matching device wins.
    always_comb begin : p_decode
        for (int h = 0; h < int'(NumHosts); h++) begin
            host_hit[h] = 1'b0;
            host_dev[h] = '0;
            for (int d = int'(NumDevs) - 1; d >= 0; d--) begin
                if ((tl_h_i[h].a_address & ~AddrMask[d]) == AddrBase[d]) begin
                    host_hit[h] = 1'b1;
                    host_dev[h] = DW'(d);
                end
            end
            host_req[h] = rst_ni && (host_state_q[h] == c_H_IDLE) &&
                          tl_h_i[h].a_valid && host_hit[h];
        end
    end

    // Grant is only issued by an IDLE device, so a BUSY device never
    // sees a_valid and never accepts a second host.
    always_comb begin : p_arb
        for (int d = 0; d < int'(NumDevs); d++) begin
            gnt_valid[d] = 1'b0;
            gnt_idx[d]   = '0;
            if (dev_state_q[d] == c_D_IDLE) begin
`ifdef TLUL_XBAR_RR_ARB_EN
                for (int i = 0; i < int'(NumHosts); i++) begin
                    if (!gnt_valid[d] &&
                        host_req[rr_idx(32'(rr_ptr_q[d]), 32'(i))] &&
                        (host_dev[rr_idx(32'(rr_ptr_q[d]), 32'(i))] == DW'(d))) begin
                        gnt_valid[d] = 1'b1;
                        gnt_idx[d]   = HW'(rr_idx(32'(rr_ptr_q[d]), 32'(i)));
                    end
                end
`else
                for (int h = int'(NumHosts) - 1; h >= 0; h--) begin
                    if (host_req[h] && (host_dev[h] == DW'(d))) begin
                        gnt_valid[d] = 1'b1;
                        gnt_idx[d]   = HW'(h);
                    end
                end
`endif
            end
        end
    end

    // An IDLE device always accepts D beats so stale responses drain.
    always_comb begin : p_dev_out
        for (int d = 0; d < int'(NumDevs); d++) begin
            tl_d_o[d] = '0;
            if (gnt_valid[d]) begin
                tl_d_o[d] = tl_h_i[gnt_idx[d]];
            end
            tl_d_o[d].d_ready = (dev_state_q[d] == c_D_BUSY) ?
                                tl_h_i[dev_owner_q[d]].d_ready : 1'b1;
        end
    end

    always_comb begin : p_host_out
        for (int h = 0; h < int'(NumHosts); h++) begin
            tl_h_o[h] = '0;
            if (err_valid_q[h]) begin
                tl_h_o[h].d_valid  = 1'b1;
                tl_h_o[h].d_opcode = err_opcode_q[h];
                tl_h_o[h].d_size   = err_size_q[h];
                tl_h_o[h].d_source = err_source_q[h];
                tl_h_o[h].d_error  = 1'b1;
            end else if (host_state_q[h] == c_H_WAIT) begin
                for (int d = 0; d < int'(NumDevs); d++) begin
                    if ((dev_state_q[d] == c_D_BUSY) && (dev_owner_q[d] == HW'(h))) begin
                        tl_h_o[h] = tl_d_i[d];
                    end
                end
            end
            tl_h_o[h].a_ready = 1'b0;
            if (host_state_q[h] == c_H_IDLE) begin
                if (!host_hit[h]) begin
                    tl_h_o[h].a_ready = 1'b1;
                end else if (gnt_valid[host_dev[h]] && (gnt_idx[host_dev[h]] == HW'(h))) begin
                    tl_h_o[h].a_ready = tl_d_i[host_dev[h]].a_ready;
                end
            end
            if (!rst_ni) begin
                tl_h_o[h].d_valid = 1'b0;
                tl_h_o[h].a_ready = 1'b0;
            end
            host_a_hs[h] = tl_h_i[h].a_valid && tl_h_o[h].a_ready;
            host_d_hs[h] = tl_h_o[h].d_valid && tl_h_i[h].d_ready;
        end
    end

    always_comb begin : p_next
        host_state_d = host_state_q;
        err_valid_d  = err_valid_q;
        err_opcode_d = err_opcode_q;
        err_size_d   = err_size_q;
        err_source_d = err_source_q;
        dev_state_d  = dev_state_q;
        dev_owner_d  = dev_owner_q;
`ifdef TLUL_XBAR_RR_ARB_EN
        rr_ptr_d     = rr_ptr_q;
`endif
        for (int h = 0; h < int'(NumHosts); h++) begin
            if ((host_state_q[h] == c_H_IDLE) && host_a_hs[h]) begin
                host_state_d[h] = c_H_WAIT;
            end else if ((host_state_q[h] == c_H_WAIT) && host_d_hs[h]) begin
                host_state_d[h] = c_H_IDLE;
            end
            if (err_valid_q[h] && tl_h_i[h].d_ready) begin
                err_valid_d[h] = 1'b0;
            end
            if (host_a_hs[h] && !host_hit[h]) begin
                err_valid_d[h]  = 1'b1;
                err_opcode_d[h] = (tl_h_i[h].a_opcode == c_OP_GET) ? c_OP_ACK_DATA : c_OP_ACK;
                err_size_d[h]   = tl_h_i[h].a_size;
                err_source_d[h] = tl_h_i[h].a_source;
            end
        end
        // A D handshake in BUSY only returns the device to IDLE; new
        // requests are arbitrated from the following cycle.
        for (int d = 0; d < int'(NumDevs); d++) begin
            if ((dev_state_q[d] == c_D_IDLE) && gnt_valid[d] && tl_d_i[d].a_ready) begin
                dev_state_d[d] = c_D_BUSY;
                dev_owner_d[d] = gnt_idx[d];
`ifdef TLUL_XBAR_RR_ARB_EN
                rr_ptr_d[d] = (gnt_idx[d] == HW'(NumHosts - 1)) ? '0 : gnt_idx[d] + 1'b1;
`endif
            end else if ((dev_state_q[d] == c_D_BUSY) && tl_d_i[d].d_valid &&
                         tl_h_i[dev_owner_q[d]].d_ready) begin
                dev_state_d[d] = c_D_IDLE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int h = 0; h < int'(NumHosts); h++) begin
                host_state_q[h] <= c_H_IDLE;
                err_valid_q[h]  <= 1'b0;
                err_opcode_q[h] <= '0;
                err_size_q[h]   <= '0;
                err_source_q[h] <= '0;
            end
            for (int d = 0; d < int'(NumDevs); d++) begin
                dev_state_q[d] <= c_D_IDLE;
                dev_owner_q[d] <= '0;
`ifdef TLUL_XBAR_RR_ARB_EN
                rr_ptr_q[d]    <= '0;
`endif
            end
        end else begin
            host_state_q <= host_state_d;
            err_valid_q  <= err_valid_d;
            err_opcode_q <= err_opcode_d;
            err_size_q   <= err_size_d;
            err_source_q <= err_source_d;
            dev_state_q  <= dev_state_d;
            dev_owner_q  <= dev_owner_d;
`ifdef TLUL_XBAR_RR_ARB_EN
            rr_ptr_q     <= rr_ptr_d;
`endif
        end
    end

endmodule
`default_nettype wire
